// File: rtl/icb_slave_pkg.sv
// Shared types and helpers for the ICB slave pipeline.
// Holds the response entry, the delay-pipe entry and register index constants.
// No logic of its own.
package icb_slave_pkg;

  // Entry stored in the response FIFO
  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  // Entry travelling through the read-latency delay pipe
  typedef struct packed {
    logic        vld;
    logic        is_sram_rd;
    logic        err;
    logic [31:0] rdata;
  } pipe_ent_t;

  localparam int STAT_IDX = 0;

  // Ceiling log2, usable in parameter expressions; clog2(1) = 0
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/icb_rsp_fifo.sv
// Synchronous response FIFO of rsp_t with occupancy count.
// Latency: push visible at the head one cycle later; head is a register read.
// Backpressure: push is dropped only when full without a same-cycle pop.
module icb_rsp_fifo
  import icb_slave_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  rsp_t          push_dat_i,
  input  logic          pop_i,
  output logic          vld_o,
  output rsp_t          head_o,
  output logic [CW-1:0] cnt_o
);

  rsp_t          mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          full, empty, do_push, do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop_i & ~empty;
  assign do_push = push_i & (~full | do_pop);

  // Storage, pointers and count; memory is cleared so the head reads 0 after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign vld_o  = ~empty;
  assign head_o = mem_q[rd_ptr_q];
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/icb_slave_pipe.sv
// Pipelined ICB slave: status/config register window plus SRAM window, in-order responses.
// Latency: response valid SRAM_RD_LAT+1 cycles after accept at the earliest.
// Backpressure: cmd_ready drops once pipe + FIFO hold RSP_DEPTH responses; FIFO head holds while stalled.
module icb_slave_pipe
  import icb_slave_pkg::*;
#(
  parameter int NUM_REGS     = 4,
  parameter int SRAM_AW      = 13,
  parameter int SRAM_SEL_BIT = 15,
  parameter int SRAM_RD_LAT  = 1,
  parameter int RSP_DEPTH    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      icb_cmd_valid,
  output logic                      icb_cmd_ready,
  input  logic                      icb_cmd_read,
  input  logic [31:0]               icb_cmd_addr,
  input  logic [31:0]               icb_cmd_wdata,
  input  logic [3:0]                icb_cmd_wmask,
  output logic                      icb_rsp_valid,
  input  logic                      icb_rsp_ready,
  output logic [31:0]               icb_rsp_rdata,
  output logic                      icb_rsp_err,
  output logic [15:0]               stat_cal,
  input  logic [15:0]               stat_evt,
  output logic [32*(NUM_REGS-1)-1:0] cfg_regs,
  output logic                      sram_wr_en,
  output logic [3:0]                sram_wr_be,
  output logic [SRAM_AW-1:0]        sram_wr_addr,
  output logic [31:0]               sram_wr_data,
  output logic                      sram_rd_en,
  output logic [SRAM_AW-1:0]        sram_rd_addr,
  input  logic [31:0]               sram_rd_data
);

  localparam int REG_IW = clog2(NUM_REGS);
  localparam int CNT_W  = clog2(RSP_DEPTH) + 1;

  logic                          accept, is_sram, unmapped, reg_wr, is_stat;
  logic [REG_IW-1:0]             reg_idx;
  logic [31:0]                   reg_rdata;
  logic [NUM_REGS-1:1][31:0]     regs_q, regs_d;
  logic [15:0]                   sticky_q, sticky_d, evt_clr;
  logic [15:0]                   stat_cal_q, stat_cal_d;
  pipe_ent_t                     pipe_in;
  pipe_ent_t                     pipe_q [SRAM_RD_LAT];
  pipe_ent_t                     pipe_out;
  rsp_t                          fifo_push_dat, fifo_head;
  logic                          fifo_vld;
  logic [CNT_W-1:0]              fifo_cnt, outstanding;
  logic                          unused_addr_bits;

  // Address bits outside both decoders are don't-care
  assign unused_addr_bits = ^{icb_cmd_addr[31:SRAM_SEL_BIT+1], icb_cmd_addr[1:0]};

  assign accept   = icb_cmd_valid & icb_cmd_ready;
  assign is_sram  = icb_cmd_addr[SRAM_SEL_BIT];
  assign reg_idx  = icb_cmd_addr[REG_IW+1:2];
  assign unmapped = ~is_sram & (|icb_cmd_addr[SRAM_SEL_BIT-1:REG_IW+2]);
  assign is_stat  = (reg_idx == REG_IW'(STAT_IDX));
  assign reg_wr   = accept & ~icb_cmd_read & ~is_sram & ~unmapped;

  // SRAM strobes are combinational in the accept cycle and zero otherwise
  assign sram_wr_en   = accept & is_sram & ~icb_cmd_read;
  assign sram_wr_be   = sram_wr_en ? icb_cmd_wmask : '0;
  assign sram_wr_addr = sram_wr_en ? icb_cmd_addr[SRAM_AW+1:2] : '0;
  assign sram_wr_data = sram_wr_en ? icb_cmd_wdata : '0;
  assign sram_rd_en   = accept & is_sram & icb_cmd_read;
  assign sram_rd_addr = sram_rd_en ? icb_cmd_addr[SRAM_AW+1:2] : '0;

  // Register read data taken from current state, i.e. before this cycle's write lands
  always_comb begin
    reg_rdata = '0;
    if (icb_cmd_read && !is_sram && !unmapped) begin
      if (is_stat) reg_rdata = {sticky_q, 16'h0};
      else         reg_rdata = regs_q[reg_idx];
    end
  end

  // Register writes, calibration pulses and sticky-event clear/set (set wins)
  always_comb begin
    regs_d     = regs_q;
    stat_cal_d = '0;
    evt_clr    = '0;
    if (reg_wr) begin
      if (is_stat) begin
        for (int b = 0; b < 2; b++) begin
          if (icb_cmd_wmask[b])   stat_cal_d[8*b +: 8] = icb_cmd_wdata[8*b +: 8];
          if (icb_cmd_wmask[b+2]) evt_clr[8*b +: 8]    = icb_cmd_wdata[16+8*b +: 8];
        end
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (icb_cmd_wmask[b]) regs_d[reg_idx][8*b +: 8] = icb_cmd_wdata[8*b +: 8];
        end
      end
    end
    sticky_d = (sticky_q & ~evt_clr) | stat_evt;
  end

  // Register state update
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q     <= '0;
      sticky_q   <= '0;
      stat_cal_q <= '0;
    end else begin
      regs_q     <= regs_d;
      sticky_q   <= sticky_d;
      stat_cal_q <= stat_cal_d;
    end
  end

  assign cfg_regs = regs_q;
  assign stat_cal = stat_cal_q;

  assign pipe_in.vld        = accept;
  assign pipe_in.is_sram_rd = sram_rd_en;
  assign pipe_in.err        = accept & unmapped;
  assign pipe_in.rdata      = reg_rdata;

  // Delay pipe aligning every response with the SRAM read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SRAM_RD_LAT; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= pipe_in;
      for (int i = 1; i < SRAM_RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign pipe_out            = pipe_q[SRAM_RD_LAT-1];
  assign fifo_push_dat.err   = pipe_out.err;
  assign fifo_push_dat.rdata = pipe_out.is_sram_rd ? sram_rd_data : pipe_out.rdata;

  // Credit count: everything in flight must fit in the FIFO, so the pipe never stalls
  always_comb begin
    outstanding = fifo_cnt;
    for (int i = 0; i < SRAM_RD_LAT; i++) outstanding = outstanding + CNT_W'(pipe_q[i].vld);
  end

  assign icb_cmd_ready = (outstanding < CNT_W'(RSP_DEPTH));

  icb_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (pipe_out.vld),
    .push_dat_i (fifo_push_dat),
    .pop_i      (icb_rsp_ready),
    .vld_o      (fifo_vld),
    .head_o     (fifo_head),
    .cnt_o      (fifo_cnt)
  );

  assign icb_rsp_valid = fifo_vld;
  assign icb_rsp_rdata = fifo_head.rdata;
  assign icb_rsp_err   = fifo_head.err;

endmodule
